// File: rtl/adder4_counter_data_selector.sv
// Selector -> adder -> loadable counter datapath.
// A 4:1 selector picks one of c0..c3, the adder sums it with an immediate,
// and the counter either loads that sum or increments each clock.
// The counter is the only state element; the selector/adder path is purely
// combinational and ignores reset.

// 4:1 data selector, {sel_b, sel_a} picks the source (sel_a is the LSB).
module data_selector #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] c3,
  input  logic             sel_a,
  input  logic             sel_b,
  output logic [WIDTH-1:0] y
);

  // Source mux
  always_comb begin
    y = c0;
    case ({sel_b, sel_a})
      2'b00:   y = c0;
      2'b01:   y = c1;
      2'b10:   y = c2;
      2'b11:   y = c3;
      default: y = c0;
    endcase
  end

endmodule

// Unsigned adder with carry-out and no carry-in; sum wraps on overflow.
module adder4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b};

endmodule

// Loadable up-counter; load beats increment, async active-low clear.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: clear on reset, else load or increment (wraps, no carry out)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q + ONE;
    end
  end

endmodule

// Top: selector output feeds the adder, whose sum is both alu_out and the
// counter's parallel-load value.
module adder4_counter_data_selector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] c3,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic [WIDTH-1:0] im,
  input  logic             load,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_co,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] sel_y;

  data_selector #(.WIDTH(WIDTH)) u_data_selector (
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .sel_a (sel_a),
    .sel_b (sel_b),
    .y     (sel_y)
  );

  adder4 #(.WIDTH(WIDTH)) u_adder4 (
    .a   (sel_y),
    .b   (im),
    .sum (alu_out),
    .co  (alu_co)
  );

  counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (alu_out),
    .q     (pc)
  );

endmodule

// File: tb/tb_adder4_counter_data_selector.sv
// Scoreboard bench for adder4_counter_data_selector: stimulus pushes
// hand-computed expectations and raises a check event; the monitor pops
// each expectation and compares it against the live DUT outputs.
module tb_adder4_counter_data_selector;

  logic       clk;
  logic       reset;
  logic [3:0] c0, c1, c2, c3;
  logic       sel_a, sel_b;
  logic [3:0] im;
  logic       load;
  logic [3:0] alu_out;
  logic       alu_co;
  logic [3:0] pc;

  logic clk_en;

  typedef struct {
    string      name;
    bit         is_pc;
    logic [3:0] val;
    logic       co;
  } exp_t;

  exp_t expq[$];
  event chk_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  adder4_counter_data_selector #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .c0      (c0),
    .c1      (c1),
    .c2      (c2),
    .c3      (c3),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .im      (im),
    .load    (load),
    .alu_out (alu_out),
    .alu_co  (alu_co),
    .pc      (pc)
  );

  // Clock held low until the bench enables it, so reset can be checked edge-free
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Monitor: pop one expectation per check event and compare with the DUT
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      tests_run++;
      if (expq.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty: check raised with no expectation queued");
      end else begin
        e = expq.pop_front();
        if (e.is_pc) begin
          if (pc !== e.val) begin
            tests_failed++;
            $display("FAIL %s: pc=%b expected %b", e.name, pc, e.val);
          end
        end else begin
          if (alu_out !== e.val || alu_co !== e.co) begin
            tests_failed++;
            $display("FAIL %s: alu_out=%b alu_co=%b expected alu_out=%b alu_co=%b",
                     e.name, alu_out, alu_co, e.val, e.co);
          end
        end
      end
    end
  end

  task automatic expect_alu(input string name, input logic [3:0] s, input logic co);
    exp_t e;
    #1;
    e.name = name; e.is_pc = 1'b0; e.val = s; e.co = co;
    expq.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic expect_pc(input string name, input logic [3:0] v);
    exp_t e;
    e.name = name; e.is_pc = 1'b1; e.val = v; e.co = 1'b0;
    expq.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Advance n rising edges and park on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk_en = 1'b0;
    reset  = 1'b0;
    c0 = 4'b0011; c1 = 4'b0101; c2 = 4'b1000; c3 = 4'b0000;
    sel_a = 1'b0; sel_b = 1'b0;
    im = 4'b0001;
    load = 1'b0;

    // Reset with no clock edges at all
    #2;
    expect_pc("reset_no_clk", 4'b0000);
    expect_alu("alu_during_reset", 4'b0100, 1'b0);

    // Release reset and count three edges
    reset = 1'b1;
    #1;
    clk_en = 1'b1;
    tick(3);
    expect_pc("count_3", 4'b0011);

    // Clear asynchronously, then walk a full wrap 0..15..0
    reset = 1'b0;
    #1;
    expect_pc("async_clear_before_wrap", 4'b0000);
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      expect_pc($sformatf("wrap_step_%0d", i), 4'(i));
    end

    // Selector sweep with im=1
    {sel_b, sel_a} = 2'b00; expect_alu("sel_00", 4'b0100, 1'b0);
    {sel_b, sel_a} = 2'b01; expect_alu("sel_01", 4'b0110, 1'b0);
    {sel_b, sel_a} = 2'b10; expect_alu("sel_10", 4'b1001, 1'b0);
    {sel_b, sel_a} = 2'b11; expect_alu("sel_11", 4'b0001, 1'b0);

    // Carry / overflow
    {sel_b, sel_a} = 2'b00;
    c0 = 4'b1111; im = 4'b0001; expect_alu("carry_f_plus_1", 4'b0000, 1'b1);
    c0 = 4'b1111; im = 4'b1111; expect_alu("carry_f_plus_f", 4'b1110, 1'b1);

    // Jump via load, then increment
    @(negedge clk);
    {sel_b, sel_a} = 2'b11; c3 = 4'b0000; im = 4'b1010; load = 1'b1;
    tick(1);
    expect_pc("jump_load", 4'b1010);
    load = 1'b0;
    tick(1);
    expect_pc("jump_then_inc", 4'b1011);

    // Load 0110, then reset mid-run with load still high
    im = 4'b0110; load = 1'b1;
    tick(1);
    expect_pc("load_0110", 4'b0110);
    #2;
    reset = 1'b0;
    #1;
    expect_pc("midrun_reset_immediate", 4'b0000);
    tick(2);
    expect_pc("midrun_reset_held", 4'b0000);
    expect_alu("alu_ignores_reset", 4'b0110, 1'b0);
    reset = 1'b1;
    tick(1);
    expect_pc("first_edge_after_reset_load", 4'b0110);
    load = 1'b0;
    tick(1);
    expect_pc("inc_after_reset_load", 4'b0111);

    // Drain scoreboard with a bound
    for (int k = 0; k < 100 && expq.size() != 0; k++) #1;
    if (expq.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adder4_counter_data_selector.md
ADDER4_COUNTER_DATA_SELECTOR -- requirements
Module: adder4_counter_data_selector

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, datapath width; all behaviour below is specified for WIDTH=4.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-005 Ports c0, c1, c2, c3, inputs, 4 bits each: selector data sources.
REQ-006 Ports sel_a, sel_b, inputs, 1 bit each: selector index bits, sel_a is the LSB.
REQ-007 Port im, input, 4 bits: immediate operand, the second adder input.
REQ-008 Port load, input, 1 bit: counter parallel-load enable.
REQ-009 Port alu_out, output, 4 bits: adder sum.
REQ-010 Port alu_co, output, 1 bit: adder carry-out.
REQ-011 Port pc, output, 4 bits: counter value.
REQ-012 The block SHALL be built from three separately instantiable submodules with these positional port orders: data_selector(c0, c1, c2, c3, sel_a, sel_b, y); adder4(a, b, sum, co); counter(clk, reset, load, d, q).

Function
REQ-013 data_selector SHALL be purely combinational: {sel_b,sel_a}=00 gives y=c0, 01 gives y=c1, 10 gives y=c2, 11 gives y=c3.
REQ-014 adder4 SHALL be purely combinational: {co,sum} = a + b as a 5-bit unsigned result, with no carry-in.
REQ-015 Adder overflow SHALL wrap: 1111+0001 gives sum=0000, co=1.
REQ-016 Top-level wiring SHALL be: selector y drives adder a; im drives adder b; adder sum drives alu_out and counter d; adder co drives alu_co; counter q drives pc.
REQ-017 On each rising clk edge with reset high, if load=1 the counter SHALL set q to d (alu_out sampled at that edge).
REQ-018 On each rising clk edge with reset high, if load=0 the counter SHALL set q to q+1.
REQ-019 The counter SHALL wrap from 1111 to 0000 on increment, with no carry output.
REQ-020 When load=1 the load SHALL take precedence over increment.
REQ-021 Latency: selector-to-alu_out/alu_co SHALL be zero cycles (combinational); alu_out-to-pc SHALL be one cycle.
REQ-022 The counter SHALL be the only state element in the block; carry is not registered inside this block.

Reset
REQ-023 While reset=0, pc SHALL be 0000 asynchronously, without waiting for a clk edge.
REQ-024 Reset asserted mid-count SHALL clear pc immediately, overriding load.
REQ-025 On the first rising edge after reset returns to 1, the counter SHALL load or increment from 0000.
REQ-026 alu_out and alu_co SHALL be unaffected by reset, tracking their inputs at all times.

Verification
REQ-027 Reset sequence: reset=0 with no clk edges -> pc=0000; then release reset, load=0, 3 edges -> pc=0011.
REQ-028 Wrap: load=0, 16 edges from pc=0000 -> pc=0000 again, sequence 0000..1111 observed with no gaps.
REQ-029 Selector/adder: c0=0011, c1=0101, c2=1000, c3=0000, im=0001; sweep {sel_b,sel_a}=00,01,10,11 -> alu_out=0100, 0110, 1001, 0001, with alu_co=0 in all four cases.
REQ-030 Carry: select c0=1111, im=0001 -> alu_out=0000, alu_co=1; then c0=1111, im=1111 -> alu_out=1110, alu_co=1.
REQ-031 Jump: sel=11 (c3=0000), im=1010, load=1, one edge -> pc=1010; then load=0, one edge -> pc=1011.
REQ-032 Async reset mid-run: pc=0110, load=1, reset pulsed low between edges -> pc=0000 immediately, and it stays 0000 until reset is released.
